// File: rtl/ge_vec_regvm_pkg.sv
// Shared types and helpers for the ge_vec_regvm register-machine executor.
// Contents:
//   op_e      - 4-bit opcode enumeration
//   state_e   - executor FSM states
//   OP_W      - opcode field width
//   instr_*   - field extractors for an instruction laid out as {op, dst, src},
//               parametrised by the register-index width rw
package ge_vec_regvm_pkg;

   localparam int unsigned OP_W        = 4;
   // Instructions are zero-extended to this width before field extraction.
   localparam int unsigned MAX_INSTR_W = 32;

   typedef enum logic [OP_W-1:0] {
      OpNop  = 4'd0,
      OpMov  = 4'd1,
      OpOr   = 4'd2,
      OpAnd  = 4'd3,
      OpXor  = 4'd4,
      OpAdd  = 4'd5,
      OpSub  = 4'd6,
      OpNot  = 4'd7,
      OpMul  = 4'd8,
      OpHalt = 4'd15
   } op_e;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_e;

   function automatic logic [OP_W-1:0] instr_op(input logic [MAX_INSTR_W-1:0] instr,
                                                 input int unsigned rw);
      return OP_W'(instr >> (2 * rw));
   endfunction

   function automatic int unsigned instr_dst(input logic [MAX_INSTR_W-1:0] instr,
                                             input int unsigned rw);
      return int'((instr >> rw) & ((MAX_INSTR_W'(1) << rw) - MAX_INSTR_W'(1)));
   endfunction

   function automatic int unsigned instr_src(input logic [MAX_INSTR_W-1:0] instr,
                                             input int unsigned rw);
      return int'(instr & ((MAX_INSTR_W'(1) << rw) - MAX_INSTR_W'(1)));
   endfunction

endpackage

// File: rtl/ge_vec_regvm_alu.sv
// Combinational ALU of the ge_vec_regvm executor.
// Ports:
//   op  - opcode (op_e encoding)
//   a   - current value of the destination register
//   b   - value of the source register
//   res - value to write back to the destination register
//   wr  - high when the opcode updates the destination register
// Build option: GE_VEC_REGVM_MUL_EN enables op 8 (MUL, low W bits of a*b);
// when undefined op 8 is a NOP and no multiplier exists.
module ge_vec_regvm_alu
   import ge_vec_regvm_pkg::*;
#(
   parameter int unsigned W = 16
) (
   input  logic [OP_W-1:0] op,
   input  logic [W-1:0]    a,
   input  logic [W-1:0]    b,
   output logic [W-1:0]    res,
   output logic            wr
);

   always_comb begin
      res = a;
      wr  = 1'b0;
      case (op)
         OpMov: begin res = b;     wr = 1'b1; end
         OpOr:  begin res = a | b; wr = 1'b1; end
         OpAnd: begin res = a & b; wr = 1'b1; end
         OpXor: begin res = a ^ b; wr = 1'b1; end
         OpAdd: begin res = a + b; wr = 1'b1; end
         OpSub: begin res = a - b; wr = 1'b1; end
         OpNot: begin res = ~b;    wr = 1'b1; end
`ifdef GE_VEC_REGVM_MUL_EN
         OpMul: begin res = a * b; wr = 1'b1; end
`endif
         // NOP, HALT and the unassigned codes leave the register file alone.
         default: ;
      endcase
   end

endmodule

// File: rtl/ge_vec_regvm.sv
// Register-machine executor for evolved vector programs. An input vector is
// latched into the register file, then a stored straight-line program runs at
// one instruction per clock; the final registers are offered on a valid/ready
// output.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   prog_we/addr/wdata - program memory write port (honoured only while idle)
//   prog_len          - instructions to run, sampled when an input is accepted
//   in_valid/in_ready/in_data    - input vector handshake, lane 0 in the LSBs
//   out_valid/out_ready/out_data - result handshake, r_0 in the LSBs
//   busy              - high while running or holding a result
// Build option: GE_VEC_REGVM_MUL_EN (see ge_vec_regvm_alu) enables MUL.
module ge_vec_regvm
   import ge_vec_regvm_pkg::*;
#(
   parameter int unsigned W     = 16,
   parameter int unsigned NREG  = 4,
   parameter int unsigned NIN   = 4,
   parameter int unsigned NOUT  = 4,
   parameter int unsigned DEPTH = 16,
   localparam int unsigned RW      = $clog2(NREG),
   localparam int unsigned INSTR_W = OP_W + 2 * RW,
   localparam int unsigned AW      = $clog2(DEPTH),
   localparam int unsigned LW      = $clog2(DEPTH + 1)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                prog_we,
   input  logic [AW-1:0]       prog_addr,
   input  logic [INSTR_W-1:0]  prog_wdata,
   input  logic [LW-1:0]       prog_len,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [NIN*W-1:0]    in_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [NOUT*W-1:0]   out_data,
   output logic                busy
);

   state_e             state_q;
   logic [W-1:0]       regs_q [NREG];
   logic [INSTR_W-1:0] mem_q  [DEPTH];
   logic [AW-1:0]      pc_q;
   logic [LW-1:0]      len_q;

   logic [INSTR_W-1:0] instr;
   logic [OP_W-1:0]    op;
   logic [RW-1:0]      dst;
   logic [RW-1:0]      src;
   logic [W-1:0]       a;
   logic [W-1:0]       b;
   logic [W-1:0]       res;
   logic               wr;
   logic               last;
   logic [LW-1:0]      len_in;
   logic [W-1:0]       in_regs [NREG];

   // Decode the instruction at pc; out-of-range register reads return 0.
   always_comb begin
      instr = mem_q[pc_q];
      op    = instr_op(MAX_INSTR_W'(instr), RW);
      dst   = RW'(instr_dst(MAX_INSTR_W'(instr), RW));
      src   = RW'(instr_src(MAX_INSTR_W'(instr), RW));
      a     = (32'(dst) < NREG) ? regs_q[dst] : '0;
      b     = (32'(src) < NREG) ? regs_q[src] : '0;
      last  = (LW'(pc_q) + LW'(1)) == len_q;
      len_in = (prog_len > LW'(DEPTH)) ? LW'(DEPTH) : prog_len;
   end

   always_comb begin
      for (int i = 0; i < NREG; i++) in_regs[i] = '0;
      for (int i = 0; i < NIN; i++) in_regs[i] = in_data[i*W +: W];
   end

   ge_vec_regvm_alu #(
      .W (W)
   ) u_alu (
      .op  (op),
      .a   (a),
      .b   (b),
      .res (res),
      .wr  (wr)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         pc_q    <= '0;
         len_q   <= '0;
         for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               // A write in the accept cycle lands before the first fetch.
               if (prog_we && (32'(prog_addr) < DEPTH)) mem_q[prog_addr] <= prog_wdata;
               if (in_valid) begin
                  for (int i = 0; i < NREG; i++) regs_q[i] <= in_regs[i];
                  pc_q    <= '0;
                  len_q   <= len_in;
                  state_q <= (len_in == '0) ? StDone : StRun;
               end
            end
            StRun: begin
               if (wr && (32'(dst) < NREG)) regs_q[dst] <= res;
               pc_q <= pc_q + AW'(1);
               if (op == OpHalt || last) state_q <= StDone;
            end
            StDone: begin
               if (out_ready) state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Registers only change while running, so the result is stable in DONE.
   always_comb begin
      for (int i = 0; i < NOUT; i++) out_data[i*W +: W] = regs_q[i];
   end

   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_ge_vec_regvm.sv
// Bench for ge_vec_regvm: directed scenarios followed by randomized programs
// checked against a behavioural interpreter of the instruction set.
module tb_ge_vec_regvm;

   localparam int unsigned W       = 16;
   localparam int unsigned NREG    = 4;
   localparam int unsigned NIN     = 4;
   localparam int unsigned NOUT    = 4;
   localparam int unsigned DEPTH   = 16;
   localparam int unsigned INSTR_W = 8;
   localparam int unsigned AW      = 4;
   localparam int unsigned LW      = 5;
   localparam int          LIMIT   = 64;

`ifdef GE_VEC_REGVM_MUL_EN
   localparam logic [15:0] MUL_EXP = 16'h0201;
`else
   localparam logic [15:0] MUL_EXP = 16'h0101;
`endif

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                prog_we = 1'b0;
   logic [AW-1:0]       prog_addr = '0;
   logic [INSTR_W-1:0]  prog_wdata = '0;
   logic [LW-1:0]       prog_len = '0;
   logic                in_valid = 1'b0;
   logic                in_ready;
   logic [NIN*W-1:0]    in_data = '0;
   logic                out_valid;
   logic                out_ready = 1'b0;
   logic [NOUT*W-1:0]   out_data;
   logic                busy;

   int tests = 0;
   int fails = 0;
   logic [INSTR_W-1:0] mdl_mem [DEPTH];

   always #5 clk = ~clk;

   ge_vec_regvm #(
      .W (W), .NREG (NREG), .NIN (NIN), .NOUT (NOUT), .DEPTH (DEPTH)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .prog_we    (prog_we),
      .prog_addr  (prog_addr),
      .prog_wdata (prog_wdata),
      .prog_len   (prog_len),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .busy       (busy)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] enc(input int op, input int d, input int s);
      return {4'(op), 2'(d), 2'(s)};
   endfunction

   function automatic logic [63:0] vec(input logic [15:0] r3, input logic [15:0] r2,
                                       input logic [15:0] r1, input logic [15:0] r0);
      return {r3, r2, r1, r0};
   endfunction

   // Interpreter: runs min(plen, DEPTH) instructions from the model memory.
   function automatic void model(input int plen, input logic [63:0] vin,
                                 output logic [63:0] vout, output int e);
      logic [15:0] r [4];
      logic [15:0] x;
      logic [15:0] y;
      logic [31:0] p;
      logic [7:0]  ins;
      int len, op, d, s;
      len = (plen > int'(DEPTH)) ? int'(DEPTH) : plen;
      for (int i = 0; i < 4; i++) r[i] = vin[16*i +: 16];
      e = 0;
      for (int pc = 0; pc < len; pc++) begin
         ins = mdl_mem[pc];
         op  = int'(ins[7:4]);
         d   = int'(ins[3:2]);
         s   = int'(ins[1:0]);
         x   = r[d];
         y   = r[s];
         e++;
         if (op == 15) break;
         case (op)
            1: r[d] = y;
            2: r[d] = x | y;
            3: r[d] = x & y;
            4: r[d] = x ^ y;
            5: r[d] = x + y;
            6: r[d] = x - y;
            7: r[d] = ~y;
`ifdef GE_VEC_REGVM_MUL_EN
            8: begin p = x * y; r[d] = p[15:0]; end
`endif
            default: p = '0;
         endcase
      end
      vout = {r[3], r[2], r[1], r[0]};
   endfunction

   // Called and returns at a falling edge; the DUT samples on the next rise.
   task automatic write_instr(input int addr, input logic [7:0] data);
      prog_we    = 1'b1;
      prog_addr  = AW'(addr);
      prog_wdata = data;
      mdl_mem[addr] = data;
      @(negedge clk);
      prog_we = 1'b0;
   endtask

   task automatic run_check(input string tag, input int plen, input logic [63:0] vin,
                            input logic [63:0] exp_out, input int exp_lat, input int hold);
      int lat;
      check({tag, " in_ready idle"}, 64'(in_ready), 64'd1);
      prog_len = LW'(plen);
      in_data  = vin;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      prog_we  = 1'b0;
      check({tag, " busy"}, 64'(busy), 64'd1);
      if (exp_lat > 1) check({tag, " in_ready run"}, 64'(in_ready), 64'd0);
      lat = 1;
      while (out_valid !== 1'b1 && lat < LIMIT) begin
         @(negedge clk);
         lat++;
      end
      check({tag, " latency"}, 64'(lat), 64'(exp_lat));
      check({tag, " data"}, out_data, exp_out);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check({tag, " hold valid"}, 64'(out_valid), 64'd1);
         check({tag, " hold in_ready"}, 64'(in_ready), 64'd0);
         check({tag, " hold data"}, out_data, exp_out);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, " released"}, 64'({out_valid, in_ready, busy}), 64'b010);
   endtask

   initial begin
      logic [63:0] v;
      logic [63:0] exp_v;
      int e, plen, lat;

      for (int i = 0; i < int'(DEPTH); i++) mdl_mem[i] = '0;

      #3;
      check("reset outputs", 64'({out_valid, in_ready, busy}), 64'b010);
      check("reset data", out_data, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // OR/XOR chain
      write_instr(0, enc(2, 2, 1));
      write_instr(1, enc(2, 3, 3));
      write_instr(2, enc(2, 3, 1));
      write_instr(3, enc(4, 3, 1));
      run_check("orxor", 4, vec(16'h1234, 16'h0101, 16'h00F0, 16'h0003),
                vec(16'h1204, 16'h01F1, 16'h00F0, 16'h0003), 5, 2);

      // Zero length: inputs pass straight through, held under backpressure
      v = vec(16'hA5A5, 16'h0F0F, 16'h1357, 16'hBEEF);
      run_check("len0", 0, v, v, 1, 10);

      // Early HALT with ADD wrap
      write_instr(0, enc(5, 0, 1));
      write_instr(1, enc(15, 0, 0));
      write_instr(2, enc(4, 0, 0));
      run_check("halt", 3, vec(16'h0, 16'h0, 16'h0002, 16'hFFFF),
                vec(16'h0, 16'h0, 16'h0002, 16'h0001), 3, 0);

      // SUB / NOT / MUL
      write_instr(0, enc(6, 0, 1));
      write_instr(1, enc(7, 1, 0));
      write_instr(2, enc(8, 2, 2));
      run_check("subnotmul", 3, vec(16'h0, 16'h0101, 16'h0002, 16'h0001),
                vec(16'h0, MUL_EXP, 16'h0000, 16'hFFFF), 4, 0);

      // Write and accept in the same idle cycle: the run sees the new word
      prog_we    = 1'b1;
      prog_addr  = '0;
      prog_wdata = enc(7, 1, 0);
      mdl_mem[0] = enc(7, 1, 0);
      run_check("samecyc", 1, vec(16'h0, 16'h0, 16'h0, 16'h5555),
                vec(16'h0, 16'h0, 16'hAAAA, 16'h5555), 2, 0);

      // Write during RUN is dropped
      write_instr(0, enc(1, 1, 0));
      for (int i = 1; i < 8; i++) write_instr(i, 8'h00);
      prog_len = LW'(8);
      in_data  = '0;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid   = 1'b0;
      prog_we    = 1'b1;
      prog_addr  = '0;
      prog_wdata = enc(7, 1, 0);
      @(negedge clk);
      prog_we = 1'b0;
      lat = 0;
      while (out_valid !== 1'b1 && lat < LIMIT) begin
         @(negedge clk);
         lat++;
      end
      check("runwr done", 64'(out_valid), 64'd1);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      run_check("runwr", 1, vec(16'h0, 16'h0, 16'h0, 16'h5555),
                vec(16'h0, 16'h0, 16'h5555, 16'h5555), 2, 0);

      // Reset in the middle of a run
      for (int i = 1; i < int'(DEPTH); i++) write_instr(i, enc(7, 3, 0));
      prog_len = LW'(16);
      in_data  = vec(16'h1111, 16'h2222, 16'h3333, 16'h4444);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst outputs", 64'({out_valid, in_ready, busy}), 64'b010);
      check("midrst data", out_data, 64'd0);
      for (int i = 0; i < int'(DEPTH); i++) mdl_mem[i] = '0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("postrst idle", 64'({out_valid, in_ready, busy}), 64'b010);
      v = {$urandom, $urandom};
      run_check("postrst nop", 16, v, v, 17, 0);

      // Randomized programs against the interpreter
      for (int it = 0; it < 40; it++) begin
         for (int k = $urandom_range(0, 8); k > 0; k--)
            write_instr($urandom_range(0, 15), 8'($urandom));
         plen = $urandom_range(0, 31);
         v = {$urandom, $urandom};
         model(plen, v, exp_v, e);
         run_check($sformatf("rand%0d", it), plen, v, exp_v, 1 + e, $urandom_range(0, 3));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
